// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/freeze/halt control for a 5-stage pipeline with perf counters.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IDRs1,
  input  logic [4:0]       IDRs2,
  input  logic             EXMemRead,
  input  logic [4:0]       EXRd,
  input  logic             EXBranchTaken,
  input  logic             HaltReq,
  input  logic             DMemReq,
  input  logic             DMemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MEMWBBubble,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic frz, eff_drain, lu, br;
  assign frz = DMemReq & ~DMemReady;
  // a resolving MEM_WAIT behaves as the state it interrupted (ret_q=1 means DRAIN)
  assign eff_drain = (state_q == DRAIN) || (state_q == MEM_WAIT && ret_q);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ret_d = ret_q;
    lu = 1'b0;
    br = 1'b0;
    {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite} = 4'b1111;
    {IFIDFlush, IDEXFlush, MEMWBBubble, Halted} = 4'b0000;
    if (state_q == HALTED) begin
      {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite} = 4'b0000;
      Halted = 1'b1;
    end else if (frz) begin
      {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite} = 4'b0000;
      MEMWBBubble = 1'b1;
      if (state_q != MEM_WAIT) begin
        state_d = MEM_WAIT;
        ret_d = state_q == DRAIN;
      end
    end else if (eff_drain) begin
      {PCWrite, IFIDWrite, IFIDFlush} = 3'b001;
      cnt_d = cnt_q - 3'd1;
      state_d = cnt_q == 3'd1 ? HALTED : DRAIN;
    end else begin
      state_d = RUN;
      lu = EXMemRead && EXRd != 5'd0 && (EXRd == IDRs1 || EXRd == IDRs2);
      if (EXBranchTaken) begin
        br = 1'b1;
        {IFIDFlush, IDEXFlush} = 2'b11;
      end else if (lu) begin
        {PCWrite, IFIDWrite, IDEXFlush} = 3'b001;
      end else if (HaltReq) begin
        state_d = DRAIN;
        cnt_d = 3'(DRAIN_CYCLES);
      end
    end
    stall_d = ((frz && state_q != HALTED) || (lu && !br)) && !(&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = br && !(&flush_q) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= 3'd0;
      ret_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ret_q <= ret_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign StallCnt = stall_q;
  assign FlushCnt = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stall, flush, freeze, drain/halt, reset and saturation.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] IDRs1, IDRs2, EXRd;
  logic EXMemRead, EXBranchTaken, HaltReq, DMemReq, DMemReady;
  logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBBubble, Halted;
  logic [15:0] StallCnt, FlushCnt;
  logic s_PCWrite, s_IFIDWrite, s_IDEXWrite, s_EXMEMWrite, s_IFIDFlush, s_IDEXFlush, s_MEMWBBubble, s_Halted;
  logic [3:0] s_StallCnt, s_FlushCnt;
  int checks = 0;
  int passes = 0;

  // {PCWrite,IFIDWrite,IDEXWrite,EXMEMWrite,IFIDFlush,IDEXFlush,MEMWBBubble,Halted}
  localparam logic [7:0] IDLE = 8'b1111_0000;
  localparam logic [7:0] FRZ  = 8'b0000_0010;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] LU   = 8'b0011_0100;
  localparam logic [7:0] DRN  = 8'b0011_1000;
  localparam logic [7:0] HLT  = 8'b0000_0001;

  wire [7:0] outs = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBBubble, Halted};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .IDRs1(IDRs1), .IDRs2(IDRs2), .EXMemRead(EXMemRead), .EXRd(EXRd),
    .EXBranchTaken(EXBranchTaken), .HaltReq(HaltReq), .DMemReq(DMemReq), .DMemReady(DMemReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite), .EXMEMWrite(EXMEMWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .MEMWBBubble(MEMWBBubble), .Halted(Halted),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .IDRs1(IDRs1), .IDRs2(IDRs2), .EXMemRead(EXMemRead), .EXRd(EXRd),
    .EXBranchTaken(EXBranchTaken), .HaltReq(HaltReq), .DMemReq(DMemReq), .DMemReady(DMemReady),
    .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite), .IDEXWrite(s_IDEXWrite), .EXMEMWrite(s_EXMEMWrite),
    .IFIDFlush(s_IFIDFlush), .IDEXFlush(s_IDEXFlush), .MEMWBBubble(s_MEMWBBubble), .Halted(s_Halted),
    .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
  );

  task automatic clear_in();
    {IDRs1, IDRs2, EXRd} = '0;
    {EXMemRead, EXBranchTaken, HaltReq, DMemReq, DMemReady} = '0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (outs !== IDLE) $display("FAIL reset_outs got %b want %b", outs, IDLE); else passes++;
    checks++; if (StallCnt !== 16'd0) $display("FAIL reset_stall got %0d want 0", StallCnt); else passes++;
    checks++; if (FlushCnt !== 16'd0) $display("FAIL reset_flush got %0d want 0", FlushCnt); else passes++;
  endtask

  task automatic test_load_use();
    EXMemRead = 1'b1; EXRd = 5'd5; IDRs2 = 5'd5; #1;
    checks++; if (outs !== LU) $display("FAIL lu_rs2_outs got %b want %b", outs, LU); else passes++;
    tick();
    clear_in();
    checks++; if (outs !== IDLE) $display("FAIL lu_one_cycle got %b want %b", outs, IDLE); else passes++;
    checks++; if (StallCnt !== 16'd1) $display("FAIL lu_stallcnt got %0d want 1", StallCnt); else passes++;
    EXMemRead = 1'b1; EXRd = 5'd0; #1;
    checks++; if (outs !== IDLE) $display("FAIL lu_rd0 got %b want %b", outs, IDLE); else passes++;
    tick();
    EXRd = 5'd7; IDRs1 = 5'd7; IDRs2 = 5'd9; #1;
    checks++; if (outs !== LU) $display("FAIL lu_rs1_outs got %b want %b", outs, LU); else passes++;
    tick();
    EXMemRead = 1'b0; #1;
    checks++; if (outs !== IDLE) $display("FAIL lu_no_memread got %b want %b", outs, IDLE); else passes++;
    checks++; if (StallCnt !== 16'd2) $display("FAIL lu_stallcnt2 got %0d want 2", StallCnt); else passes++;
    clear_in();
  endtask

  task automatic test_branch_priority();
    EXBranchTaken = 1'b1; EXMemRead = 1'b1; EXRd = 5'd3; IDRs1 = 5'd3; HaltReq = 1'b1; #1;
    checks++; if (outs !== BR) $display("FAIL br_outs got %b want %b", outs, BR); else passes++;
    tick();
    clear_in();
    checks++; if (FlushCnt !== 16'd1) $display("FAIL br_flushcnt got %0d want 1", FlushCnt); else passes++;
    checks++; if (StallCnt !== 16'd2) $display("FAIL br_stallcnt got %0d want 2", StallCnt); else passes++;
    checks++; if (outs !== IDLE) $display("FAIL br_stays_run got %b want %b", outs, IDLE); else passes++;
  endtask

  task automatic test_mem_wait();
    DMemReq = 1'b1; DMemReady = 1'b0; EXBranchTaken = 1'b1; HaltReq = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (outs !== FRZ) $display("FAIL mw_freeze%0d got %b want %b", i, outs, FRZ); else passes++;
      tick();
    end
    DMemReady = 1'b1; EXBranchTaken = 1'b0; HaltReq = 1'b0; #1;
    checks++; if (outs !== IDLE) $display("FAIL mw_release got %b want %b", outs, IDLE); else passes++;
    checks++; if (StallCnt !== 16'd6) $display("FAIL mw_stallcnt got %0d want 6", StallCnt); else passes++;
    checks++; if (FlushCnt !== 16'd1) $display("FAIL mw_flushcnt got %0d want 1", FlushCnt); else passes++;
    tick();
    clear_in();
    EXMemRead = 1'b1; EXRd = 5'd4; IDRs1 = 5'd4; #1;
    checks++; if (outs !== LU) $display("FAIL mw_back_in_run got %b want %b", outs, LU); else passes++;
    tick();
    clear_in();
  endtask

  task automatic test_halt();
    HaltReq = 1'b1; #1;
    checks++; if (outs !== IDLE) $display("FAIL halt_issue got %b want %b", outs, IDLE); else passes++;
    tick();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      EXBranchTaken = (i == 1); HaltReq = (i == 2); EXMemRead = 1'b1; EXRd = 5'd6; IDRs1 = 5'd6; #1;
      checks++; if (outs !== DRN) $display("FAIL drain%0d got %b want %b", i, outs, DRN); else passes++;
      tick();
    end
    clear_in();
    checks++; if (outs !== HLT) $display("FAIL halted got %b want %b", outs, HLT); else passes++;
    checks++; if (FlushCnt !== 16'd1) $display("FAIL drain_flushcnt got %0d want 1", FlushCnt); else passes++;
    checks++; if (StallCnt !== 16'd7) $display("FAIL drain_stallcnt got %0d want 7", StallCnt); else passes++;
    DMemReq = 1'b1; EXBranchTaken = 1'b1; #1;
    checks++; if (outs !== HLT) $display("FAIL halted_ignores got %b want %b", outs, HLT); else passes++;
    tick();
    checks++; if (StallCnt !== 16'd7) $display("FAIL halted_stallcnt got %0d want 7", StallCnt); else passes++;
    clear_in();
    reset = 1'b1; #1;
    checks++; if (outs !== HLT) $display("FAIL reset_cycle_decode got %b want %b", outs, HLT); else passes++;
    tick();
    reset = 1'b0; #1;
    checks++; if (outs !== IDLE) $display("FAIL halt_reset_outs got %b want %b", outs, IDLE); else passes++;
    checks++; if (StallCnt !== 16'd0 || FlushCnt !== 16'd0)
      $display("FAIL halt_reset_cnts got %0d/%0d want 0/0", StallCnt, FlushCnt); else passes++;
  endtask

  task automatic test_drain_wait();
    HaltReq = 1'b1; #1;
    tick();
    clear_in();
    checks++; if (outs !== DRN) $display("FAIL dw_drain1 got %b want %b", outs, DRN); else passes++;
    tick();
    DMemReq = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (outs !== FRZ) $display("FAIL dw_freeze%0d got %b want %b", i, outs, FRZ); else passes++;
      tick();
    end
    DMemReady = 1'b1; #1;
    checks++; if (outs !== DRN) $display("FAIL dw_resume got %b want %b", outs, DRN); else passes++;
    tick();
    clear_in();
    checks++; if (outs !== DRN) $display("FAIL dw_drain3 got %b want %b", outs, DRN); else passes++;
    tick();
    checks++; if (outs !== HLT) $display("FAIL dw_halted got %b want %b", outs, HLT); else passes++;
    checks++; if (StallCnt !== 16'd2) $display("FAIL dw_stallcnt got %0d want 2", StallCnt); else passes++;
  endtask

  task automatic test_reset_midwait();
    reset = 1'b1; tick(); reset = 1'b0;
    HaltReq = 1'b1; #1;
    tick();
    clear_in();
    DMemReq = 1'b1; #1;
    tick();
    reset = 1'b1; #1;
    checks++; if (outs !== FRZ) $display("FAIL rmw_during got %b want %b", outs, FRZ); else passes++;
    tick();
    reset = 1'b0;
    clear_in();
    checks++; if (outs !== IDLE) $display("FAIL rmw_after got %b want %b", outs, IDLE); else passes++;
    checks++; if (StallCnt !== 16'd0 || FlushCnt !== 16'd0)
      $display("FAIL rmw_cnts got %0d/%0d want 0/0", StallCnt, FlushCnt); else passes++;
    tick();
    checks++; if (outs !== IDLE) $display("FAIL rmw_not_drain got %b want %b", outs, IDLE); else passes++;
  endtask

  task automatic test_saturation();
    reset = 1'b1; tick(); reset = 1'b0;
    DMemReq = 1'b1; #1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (s_StallCnt !== 4'd15) $display("FAIL sat_at15 got %0d want 15", s_StallCnt); else passes++;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (s_StallCnt !== 4'd15) $display("FAIL sat_hold got %0d want 15", s_StallCnt); else passes++;
    checks++; if (StallCnt !== 16'd20) $display("FAIL sat_wide got %0d want 20", StallCnt); else passes++;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_halt();
    test_drain_wait();
    test_reset_midwait();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, number of bubble cycles issued after a halt before Halted asserts (range 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have ports, one clock, synchronous active-high reset:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- IDRs1  in  5  rs1 of instruction in ID (IF/ID CurrInstr[19:15])
- IDRs2  in  5  rs2 of instruction in ID (IF/ID CurrInstr[24:20])
- EXMemRead  in  1  ID/EX MemRead
- EXRd  in  5  ID/EX WriteRegister
- EXBranchTaken  in  1  branch/jump resolved taken in EX
- HaltReq  in  1  halt instruction decoded in ID
- DMemReq  in  1  MEM stage access (EX/MEM MemRead|MemWrite)
- DMemReady  in  1  data memory completes access this cycle
- PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite  out  1 each  register enables
- IFIDFlush, IDEXFlush  out  1 each  load bubble (all-zero) into IF/ID, ID/EX
- MEMWBBubble  out  1  load bubble into MEM/WB
- Halted  out  1  pipeline stopped
- StallCnt  out  CNT_W  stall cycles
- FlushCnt  out  CNT_W  branch flushes

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED plus a 3-bit drain counter and a 1-bit return-state register (RUN or DRAIN).
REQ-005 Idle outputs: all four enables 1, IFIDFlush/IDEXFlush/MEMWBBubble 0, Halted 0.
REQ-006 Freeze F = DMemReq & ~DMemReady; in RUN, DRAIN, MEM_WAIT, F SHALL combinationally drive all four enables 0, MEMWBBubble 1, both flushes 0, and F SHALL take priority over every other condition.
REQ-007 F in RUN or DRAIN SHALL move FSM to MEM_WAIT, saving current state as return state; drain counter SHALL not change while F.
REQ-008 MEM_WAIT with DMemReady=1 SHALL give non-frozen behaviour of the saved state that cycle and return to it next cycle.
REQ-009 Branch flush: in RUN, ~F & EXBranchTaken SHALL assert IFIDFlush=1, IDEXFlush=1, PCWrite=1, ignoring load-use and HaltReq that cycle.
REQ-010 Load-use: in RUN, ~F & ~EXBranchTaken & EXMemRead & EXRd!=0 & (EXRd==IDRs1 | EXRd==IDRs2) SHALL drive PCWrite=0, IFIDWrite=0, IDEXFlush=1 for exactly that cycle; no state change.
REQ-011 Halt: in RUN, HaltReq with no F, branch or load-use SHALL move to DRAIN, loading drain counter with DRAIN_CYCLES; that cycle outputs are idle (halt instruction advances to EX).
REQ-012 DRAIN, ~F: PCWrite=0, IFIDWrite=0, IFIDFlush=1, other enables 1; counter decrements; at counter==1 next state HALTED.
REQ-013 DRAIN SHALL ignore EXBranchTaken, HaltReq and load-use inputs.
REQ-014 HALTED: all four enables 0, flushes/bubble 0, Halted=1; all inputs ignored; exit only by reset.
REQ-015 StallCnt SHALL increment by 1 per cycle in which F or load-use stall (REQ-010) is active, saturating at all-ones.
REQ-016 FlushCnt SHALL increment by 1 per REQ-009 cycle, saturating at all-ones.
REQ-017 EXRd==0 SHALL never cause a load-use stall.

Reset
REQ-018 reset=1 at a rising edge SHALL set state RUN, drain counter 0, return state RUN, StallCnt=0, FlushCnt=0, Halted=0, from any state including mid-MEM_WAIT and mid-DRAIN.
REQ-019 During a reset cycle outputs SHALL be decoded from current state; from the cycle after, idle RUN outputs apply.

Verification
REQ-020 Load-use: EXMemRead=1, EXRd=5, IDRs2=5, one cycle -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 that cycle only, StallCnt 0->1; repeat with EXRd=0 -> no stall.
REQ-021 Branch vs load-use vs halt: EXBranchTaken=1 with load-use match and HaltReq=1 -> IFIDFlush=IDEXFlush=1, PCWrite=1, FlushCnt=1, state stays RUN.
REQ-022 Memory wait: DMemReq=1, DMemReady=0 for 4 cycles then 1 -> enables 0, MEMWBBubble=1 for 4 cycles, fifth cycle idle outputs, StallCnt=4, back to RUN.
REQ-023 Halt: HaltReq=1 one cycle in RUN -> 3 DRAIN cycles with IFIDFlush=1, PCWrite=0; Halted=1 on 5th cycle; DMemReady=0 during DRAIN extends drain by the wait length.
REQ-024 Reset mid-MEM_WAIT (saved DRAIN) and in HALTED -> next cycle RUN, Halted=0, counters 0, idle outputs.
REQ-025 Saturation: CNT_W=4, 20 consecutive freeze cycles -> StallCnt holds 15.
